// File: rtl/fetch_align_buffer.sv
// Fetch/align buffer: requests I-cache lines, queues halfwords and presents
// aligned 16/32-bit instructions with their PC to decode.
module fetch_align_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     FETCH_W  = 64,
  parameter int unsigned     DEPTH_HW = 16,
  parameter logic [XLEN-1:0] PC_RESET = 32'h8000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [XLEN-1:0]              flush_pc_i,
  output logic                         ic_req_o,
  output logic [XLEN-1:0]              ic_addr_o,
  output logic                         ic_kill_o,
  input  logic                         ic_ack_i,
  input  logic [FETCH_W-1:0]           ic_rdata_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_instr_o,
  output logic                         out_is_cmp_o,
  output logic [XLEN-1:0]              out_pc_o,
  output logic                         out_misalign_o,
  output logic [$clog2(DEPTH_HW):0]    count_o
);

  localparam int unsigned H    = FETCH_W / 16;
  localparam int unsigned PW   = $clog2(DEPTH_HW);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned OFFW = $clog2(FETCH_W / 8);
  localparam int unsigned DW   = OFFW - 1;
  localparam logic [XLEN-1:0] PC_RESET_AL = {PC_RESET[XLEN-1:OFFW], {OFFW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     buf_q [DEPTH_HW];
  logic [PW:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d, out_pc_q, out_pc_d;
  logic [DW-1:0]   discard_q, discard_d;
  logic            mis_q, mis_d;

  logic [CW-1:0]   count_s, free_s, n_wr_s, free_post_s, pop_hw_s;
  logic [PW-1:0]   head_idx_s, next_idx_s;
  logic [15:0]     head_s, next_s;
  logic            full_s, empty_s, is_cmp_s, valid_s;
  logic            ack_acc_s, pop_s, pop_instr_s, pop_mis_s;

  assign count_s     = wr_ptr_q - rd_ptr_q;
  assign free_s      = CW'(DEPTH_HW) - count_s;
  assign n_wr_s      = CW'(H) - CW'(discard_q);
  assign free_post_s = free_s - n_wr_s;
  assign full_s      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty_s     = (wr_ptr_q == rd_ptr_q);

  assign head_idx_s  = rd_ptr_q[PW-1:0];
  assign next_idx_s  = head_idx_s + PW'(1'b1);
  assign head_s      = buf_q[head_idx_s];
  assign next_s      = buf_q[next_idx_s];
  assign is_cmp_s    = (head_s[1:0] != 2'b11);
  assign pop_hw_s    = is_cmp_s ? CW'(1'b1) : CW'(2'd2);

  // A flush cycle drops both the cache response and any pop.
  assign ack_acc_s   = (state_q == ST_REQ) && ic_ack_i && !flush_i && !full_s;
  assign pop_s       = valid_s && out_ready_i && !flush_i;
  assign pop_instr_s = pop_s && (state_q != ST_HALT);
  assign pop_mis_s   = pop_s && (state_q == ST_HALT);

  // Decode head of buffer, or present the misalign marker while halted.
  always_comb begin
    valid_s        = 1'b0;
    out_instr_o    = 32'h0;
    out_is_cmp_o   = 1'b0;
    out_misalign_o = 1'b0;
    if (state_q == ST_HALT) begin
      valid_s        = mis_q;
      out_misalign_o = mis_q;
    end else begin
      valid_s      = !empty_s && (is_cmp_s || (count_s >= CW'(2'd2)));
      out_instr_o  = is_cmp_s ? {16'h0, head_s} : {next_s, head_s};
      out_is_cmp_o = is_cmp_s;
    end
  end

  assign out_valid_o = valid_s;
  assign out_pc_o    = out_pc_q;
  assign ic_addr_o   = fetch_addr_q;
  assign count_o     = count_s;

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fetch FSM next state; space checks use the registered count only.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = flush_pc_i[0] ? ST_HALT : ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = ack_acc_s ? ((free_post_s >= CW'(H)) ? ST_REQ : ST_WAIT) : ST_REQ;
        ST_WAIT: state_d = (free_s >= CW'(H)) ? ST_REQ : ST_WAIT;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Fetch FSM outputs.
  always_comb begin
    ic_req_o  = 1'b0;
    ic_kill_o = 1'b0;
    case (state_q)
      ST_REQ: begin
        ic_req_o  = 1'b1;
        ic_kill_o = flush_i;
      end
      ST_IDLE, ST_WAIT, ST_HALT: begin
        ic_req_o  = 1'b0;
        ic_kill_o = 1'b0;
      end
      default: begin
        ic_req_o  = 1'b0;
        ic_kill_o = 1'b0;
      end
    endcase
  end

  // Pointer, PC and discard next-state.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fetch_addr_d = fetch_addr_q;
    out_pc_d     = out_pc_q;
    discard_d    = discard_q;
    mis_d        = mis_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fetch_addr_d = {flush_pc_i[XLEN-1:OFFW], {OFFW{1'b0}}};
      out_pc_d     = flush_pc_i;
      discard_d    = flush_pc_i[OFFW-1:1];
      mis_d        = flush_pc_i[0];
    end else begin
      wr_ptr_d     = ack_acc_s ? (wr_ptr_q + n_wr_s) : wr_ptr_q;
      fetch_addr_d = ack_acc_s ? (fetch_addr_q + XLEN'(FETCH_W / 8)) : fetch_addr_q;
      discard_d    = ack_acc_s ? '0 : discard_q;
      rd_ptr_d     = pop_instr_s ? (rd_ptr_q + pop_hw_s) : rd_ptr_q;
      out_pc_d     = pop_instr_s ? (out_pc_q + (is_cmp_s ? XLEN'(3'd2) : XLEN'(3'd4))) : out_pc_q;
      mis_d        = mis_q && !pop_mis_s;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= PC_RESET_AL;
      out_pc_q     <= PC_RESET_AL;
      discard_q    <= '0;
      mis_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      out_pc_q     <= out_pc_d;
      discard_q    <= discard_d;
      mis_q        <= mis_d;
    end
  end

  // Halfword storage; leading halfwords below the discard count are skipped.
  always_ff @(posedge clk) begin
    if (rst_n && ack_acc_s) begin
      for (int i = 0; i < int'(H); i++) begin
        if (i >= int'(discard_q)) begin
          buf_q[PW'(int'(wr_ptr_q[PW-1:0]) + i - int'(discard_q))] <= ic_rdata_i[16*i +: 16];
        end
      end
    end
  end

endmodule

// File: doc/fetch_align_buffer.md
FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

Interface
REQ-001 Parameter XLEN, default 32, address/PC width.
REQ-002 Parameter FETCH_W, default 64, I-cache response width in bits; legal values 32, 64, 128; H = FETCH_W/16 halfwords per response.
REQ-003 Parameter DEPTH_HW, default 16, buffer depth in halfwords; power of 2, >= 2*H.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 flush_i  in  1  redirect request (branch, jump, trap, wfi resume).
REQ-007 flush_pc_i  in  XLEN  redirect target PC.
REQ-008 ic_req_o  out  1  I-cache request valid.
REQ-009 ic_addr_o  out  XLEN  request address, aligned to FETCH_W/8 bytes.
REQ-010 ic_kill_o  out  1  abort the outstanding request.
REQ-011 ic_ack_i  in  1  response valid; completes the request.
REQ-012 ic_rdata_i  in  FETCH_W  response data, little-endian halfwords.
REQ-013 out_valid_o  out  1  instruction available to decode.
REQ-014 out_ready_i  in  1  decode accepts the instruction.
REQ-015 out_instr_o  out  32  instruction; compressed returned in [15:0] with [31:16]=0.
REQ-016 out_is_cmp_o  out  1  instruction is 16-bit (bits[1:0] != 2'b11).
REQ-017 out_pc_o  out  XLEN  PC of out_instr_o.
REQ-018 out_misalign_o  out  1  instruction-address-misaligned exception marker.
REQ-019 count_o  out  clog2(DEPTH_HW)+1  occupied halfwords.

Function
REQ-020 Buffer: circular halfword FIFO; rd/wr pointers carry an extra wrap bit; full when the MSBs differ and the rest are equal; empty when all bits are equal.
REQ-021 Fetch FSM states: IDLE, REQ, WAIT_SPACE, HALT.
REQ-022 REQ: ic_req_o=1; ic_addr_o=fetch_addr, held stable until ic_ack_i.
REQ-023 On ic_ack_i in REQ:
- write H halfwords, minus the pending discard count, at wr_ptr;
- fetch_addr += FETCH_W/8, wrapping mod 2^XLEN;
- next state is REQ if post-write free space >= H, else WAIT_SPACE.
REQ-024 Only one request SHALL be outstanding at any time.
REQ-025 Free space is evaluated on registered count; pops in the same cycle are not credited until the next cycle.
REQ-026 WAIT_SPACE -> REQ when free >= H.
REQ-027 Decode head:
- if head[1:0] != 2'b11: compressed, needs 1 halfword;
- else 32-bit, needs 2 halfwords, low half at head, high half at head+1, modulo DEPTH_HW.
REQ-028 out_valid_o=1 only when count >= required halfwords and the state is not HALT-misalign.
REQ-029 out_valid_o, out_instr_o, out_pc_o SHALL be held stable while out_valid_o=1 and out_ready_i=0.
REQ-030 Pop on out_valid_o & out_ready_i:
- rd_ptr += 1 or 2;
- out_pc += 2 or 4, wrapping mod 2^XLEN.
REQ-031 Simultaneous ack write and pop in one cycle:
- count_next = count + written - popped;
- the write to a full buffer never occurs, guaranteed by REQ-023/025.
REQ-032 Flush handling (highest priority), next cycle:
- buffer emptied;
- fetch_addr = flush_pc_i aligned down to FETCH_W/8;
- out_pc = flush_pc_i;
- discard count = flush_pc_i[log2(FETCH_W/8)-1:1];
- state = REQ.
REQ-033 If a request is outstanding when flush_i=1, ic_kill_o=1 for that cycle; an ic_ack_i in the same cycle is ignored.
REQ-034 Discard count applies to the first accepted response after a flush, then clears to 0.
REQ-035 Flush with flush_pc_i[0]=1:
- state = HALT; no requests issued;
- one cycle later out_valid_o=1, out_misalign_o=1, out_pc_o=flush_pc_i, out_instr_o=0;
- the marker is held until accepted; thereafter out_valid_o=0 until the next flush.
REQ-036 HALT is left only via flush_i.
REQ-037 A flush during a pending pop cancels the pop.

Reset
REQ-038 rst_n=0 at a rising edge SHALL, regardless of in-flight activity:
- empty the buffer, count_o=0, discard=0;
- fetch_addr and out_pc = PC_RESET aligned per REQ-032;
- state=IDLE;
- outputs ic_req_o=0, ic_kill_o=0, out_valid_o=0, out_misalign_o=0.
REQ-039 The first cycle after reset release SHALL move IDLE -> REQ.
REQ-040 An ic_ack_i arriving during or immediately after reset SHALL be ignored.

Verification
REQ-041 Reset PC_RESET=0x80000000, FETCH_W=64, ack with 4x32-bit instrs across 2 lines, ready=1 -> 4 outputs, PCs 0x80000000/04/08/0C, is_cmp=0.
REQ-042 Flush to 0x80000006, line holds a 32-bit instr at offset 6 -> discard=3, first output waits for the second line, pc=0x80000006, instr={line2.hw0, line1.hw3}.
REQ-043 Mixed stream C,C,32,C from 0x100 -> PCs 0x100, 0x102, 0x104, 0x108; compressed outputs have [31:16]=0.
REQ-044 out_ready_i=0 for 20 cycles with DEPTH_HW=16 -> fills to count 16, FSM in WAIT_SPACE, no ic_req_o; ready=1 resumes fetching once free >= 4.
REQ-045 flush_i=1 in the same cycle as ic_ack_i -> ic_kill_o=1, data dropped, next ic_addr_o = new aligned target.
REQ-046 Flush to 0x201 -> out_misalign_o=1, pc=0x201, then silence until the next flush.
